// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the timing bundle
// handed from the sync generator to pixel renderers.
package vga_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL =
    VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL =
    VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int POS_W = 10;

  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    pos_t hpos;
    pos_t vpos;
    logic hsync;
    logic vsync;
    logic display_on;
  } vga_timing_t;

  function automatic logic in_range(
    input pos_t v,
    input int   lo,
    input int   hi
  );
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_sync_timing_if.sv
// Raster timing bundle: generator drives it, renderers
// consume it.
interface vga_sync_timing_if
  import vga_pkg::*;
;
  logic pixel_tick;
  logic hsync;
  logic vsync;
  logic display_on;
  pos_t hpos;
  pos_t vpos;

  modport master (
    output pixel_tick,
    output hsync,
    output vsync,
    output display_on,
    output hpos,
    output vpos
  );

  modport slave (
    input pixel_tick,
    input hsync,
    input vsync,
    input display_on,
    input hpos,
    input vpos
  );

endinterface

// File: rtl/vga_pixel_clk_en.sv
// Pixel-rate clock enable: one-clk pulse every CLK_DIV
// system clocks, first pulse CLK_DIV edges after reset.
module vga_pixel_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;
  logic         last;

  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      pixel_tick <= 1'b0;
    end else begin
      cnt        <= last ? '0 : cnt + 1'b1;
      pixel_tick <= last;
    end
  end

endmodule

// File: rtl/vga_sync_timing.sv
// VGA raster counters and sync decode; all outputs come
// from one register bank so they carry zero mutual skew.
module vga_sync_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV          = 2,
  parameter int H_DISPLAY        = VGA_H_DISPLAY,
  parameter int H_FRONT          = VGA_H_FRONT,
  parameter int H_SYNC           = VGA_H_SYNC,
  parameter int H_BACK           = VGA_H_BACK,
  parameter int V_DISPLAY        = VGA_V_DISPLAY,
  parameter int V_FRONT          = VGA_V_FRONT,
  parameter int V_SYNC           = VGA_V_SYNC,
  parameter int V_BACK           = VGA_V_BACK,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic               clk,
  input  logic               reset,
  vga_sync_timing_if.master  vga
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO = H_DISPLAY + H_FRONT;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_DISPLAY + V_FRONT;
  localparam int VS_HI = VS_LO + V_SYNC;
  localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);
  localparam logic SYNC_ON =
    (SYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;

  logic        tick;
  vga_timing_t cur;
  vga_timing_t nxt;

  vga_pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (tick)
  );

  // Decode looks at the next position so it registers
  // alongside the counters it describes.
  always_comb begin
    nxt = cur;
    if (tick) begin
      if (cur.hpos == H_LAST) begin
        nxt.hpos = '0;
        nxt.vpos = (cur.vpos == V_LAST) ?
          '0 : cur.vpos + 10'd1;
      end else begin
        nxt.hpos = cur.hpos + 10'd1;
      end
    end
    nxt.hsync = in_range(nxt.hpos, HS_LO, HS_HI) ?
      SYNC_ON : ~SYNC_ON;
    nxt.vsync = in_range(nxt.vpos, VS_LO, VS_HI) ?
      SYNC_ON : ~SYNC_ON;
    nxt.display_on =
      in_range(nxt.hpos, 0, H_DISPLAY) &&
      in_range(nxt.vpos, 0, V_DISPLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur.hpos       <= '0;
      cur.vpos       <= '0;
      cur.hsync      <= ~SYNC_ON;
      cur.vsync      <= ~SYNC_ON;
      cur.display_on <= 1'b1;
    end else begin
      cur <= nxt;
    end
  end

  assign vga.pixel_tick = tick;
  assign vga.hpos       = cur.hpos;
  assign vga.vpos       = cur.vpos;
  assign vga.hsync      = cur.hsync;
  assign vga.vsync      = cur.vsync;
  assign vga.display_on = cur.display_on;

  totals_fit_counters : assert property (
    @(posedge clk) (H_TOTAL <= 1024) && (V_TOTAL <= 1024)
  );

endmodule

// File: tb/tb_vga_sync_timing.sv
// Directed bench: several parameterisations run side by
// side against a closed-form raster model.
module tb_vga_sync_timing;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vga_sync_timing_if i2 ();
  vga_sync_timing_if i1 ();
  vga_sync_timing_if i4 ();
  vga_sync_timing_if ih ();
  vga_sync_timing_if is ();

  vga_sync_timing #(.CLK_DIV(2)) u2 (
    .clk(clk), .reset(reset), .vga(i2));
  vga_sync_timing #(.CLK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .vga(i1));
  vga_sync_timing #(.CLK_DIV(4)) u4 (
    .clk(clk), .reset(reset), .vga(i4));
  vga_sync_timing #(
    .CLK_DIV(2), .SYNC_ACTIVE_HIGH(1)
  ) uh (
    .clk(clk), .reset(reset), .vga(ih));
  vga_sync_timing #(
    .CLK_DIV(1),
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) us (
    .clk(clk), .reset(reset), .vga(is));

  task automatic check(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // k = posedges since reset release, sampled 1 ns later
  task automatic cmp_dut(
    input string      nm,
    input int         k,
    input int         d,
    input int         hd,
    input int         hf,
    input int         hs,
    input int         hb,
    input int         vd,
    input int         vf,
    input int         vs,
    input int         vb,
    input int         sah,
    input logic       tk,
    input logic       hsy,
    input logic       vsy,
    input logic       de,
    input logic [9:0] hp,
    input logic [9:0] vp
  );
    int   ht, vt, p, eh, ev;
    logic ha, va;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    p  = (k - 1) / d;
    eh = p % ht;
    ev = (p / ht) % vt;
    ha = (eh >= hd + hf) && (eh < hd + hf + hs);
    va = (ev >= vd + vf) && (ev < vd + vf + vs);
    check({nm, ".tick"}, int'(tk), int'(k % d == 0));
    check({nm, ".hpos"}, int'(hp), eh);
    check({nm, ".vpos"}, int'(vp), ev);
    check({nm, ".hsync"}, int'(hsy),
          int'((sah != 0) ? ha : !ha));
    check({nm, ".vsync"}, int'(vsy),
          int'((sah != 0) ? va : !va));
    check({nm, ".de"}, int'(de),
          int'((eh < hd) && (ev < vd)));
  endtask

  initial begin
    int ticks0, hs_low, de_low, vs_low;
    ticks0 = 0;
    hs_low = 0;
    de_low = 0;
    vs_low = 0;

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (300) @(posedge clk);

    // mid-line async reset, checked before the next edge
    #3 reset = 1'b1;
    #1;
    check("rst.hpos", int'(i2.hpos), 0);
    check("rst.vpos", int'(i2.vpos), 0);
    check("rst.hsync", int'(i2.hsync), 1);
    check("rst.vsync", int'(i2.vsync), 1);
    check("rst.de", int'(i2.display_on), 1);
    check("rst.tick", int'(i2.pixel_tick), 0);
    check("rst.tick1", int'(i1.pixel_tick), 0);
    check("rst.h_hsync", int'(ih.hsync), 0);
    check("rst.h_vsync", int'(ih.vsync), 0);
    check("rst.s_hpos", int'(is.hpos), 0);

    @(negedge clk);
    @(negedge clk) reset = 1'b0;

    for (int k = 1; k <= 1700; k++) begin
      @(posedge clk);
      #1;
      cmp_dut("d2", k, 2, 640, 16, 96, 48,
              480, 10, 2, 33, 0,
              i2.pixel_tick, i2.hsync, i2.vsync,
              i2.display_on, i2.hpos, i2.vpos);
      cmp_dut("d1", k, 1, 640, 16, 96, 48,
              480, 10, 2, 33, 0,
              i1.pixel_tick, i1.hsync, i1.vsync,
              i1.display_on, i1.hpos, i1.vpos);
      cmp_dut("d4", k, 4, 640, 16, 96, 48,
              480, 10, 2, 33, 0,
              i4.pixel_tick, i4.hsync, i4.vsync,
              i4.display_on, i4.hpos, i4.vpos);
      cmp_dut("hi", k, 2, 640, 16, 96, 48,
              480, 10, 2, 33, 1,
              ih.pixel_tick, ih.hsync, ih.vsync,
              ih.display_on, ih.hpos, ih.vpos);
      cmp_dut("sm", k, 1, 8, 2, 3, 2,
              6, 2, 2, 3, 0,
              is.pixel_tick, is.hsync, is.vsync,
              is.display_on, is.hpos, is.vpos);
      if (i2.pixel_tick && i2.vpos == 10'd0) begin
        ticks0++;
        if (!i2.hsync) hs_low++;
        if (!i2.display_on) de_low++;
      end
      if (k <= 195 && !is.vsync) vs_low++;
      if (k == 195) begin
        check("sm.last_h", int'(is.hpos), 14);
        check("sm.last_v", int'(is.vpos), 12);
      end
      if (k == 196) begin
        check("sm.wrap_h", int'(is.hpos), 0);
        check("sm.wrap_v", int'(is.vpos), 0);
      end
    end

    check("line.ticks", ticks0, 800);
    check("line.hs_low", hs_low, 96);
    check("line.de_low", de_low, 160);
    check("frame.vs_low", vs_low, 30);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
